// File: rtl/uart_rx_buf_con_pkg.sv
// rtl/uart_rx_buf_con_pkg.sv - shared byte constants and types for the UART line assembler
package uart_rx_buf_con_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam int         LINE_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    BC_DATA = 2'd0,
    BC_TERM = 2'd1,
    BC_BS   = 2'd2
  } byte_class_e;

  function automatic byte_class_e classify_byte(input logic [7:0] b, input logic bs_en);
    if (b == ASCII_CR || b == ASCII_LF) return BC_TERM;
    if (b == ASCII_BS && bs_en)         return BC_BS;
    return BC_DATA;
  endfunction

endpackage

// File: rtl/uart_rx_buf_con.sv
// rtl/uart_rx_buf_con.sv - packs received bytes into 64-bit lines delivered on CR/LF
module uart_rx_buf_con
  import uart_rx_buf_con_pkg::*;
#(
  parameter bit DROP_EMPTY = 1'b1,
  parameter bit BS_ENABLE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rbus,
  input  logic        rvalid,
  output logic [63:0] lbuf,
  output logic [3:0]  llen,
  output logic        lovf,
  output logic        lvalid,
  input  logic        lack,
  output logic        overrun
);

  localparam logic [3:0] LINE_BYTES_W = 4'(LINE_BYTES);

  rx_state_e   r_state;
  rx_state_e   w_next_state;
  byte_class_e w_class;
  logic [63:0] r_abuf;
  logic [3:0]  r_acnt;
  logic [3:0]  w_acnt_dec;
  logic [63:0] w_ins;
  logic [63:0] w_del_mask;
  logic        w_store;
  logic        w_unstore;
  logic        w_deliver;
  logic        w_clear;
  logic        w_line_ovf;
  logic [63:0] r_lbuf;
  logic [3:0]  r_llen;
  logic        r_lovf;
  logic        r_lvalid;
  logic        r_overrun;

  assign w_class    = classify_byte(rbus, BS_ENABLE);
  assign w_acnt_dec = r_acnt - 4'd1;
  // Slot k occupies bits [63-8k -: 8], so the byte is shifted down from the top.
  assign w_ins      = {rbus, 56'd0} >> {r_acnt[2:0], 3'b000};
  assign w_del_mask = {8'hFF, 56'd0} >> {w_acnt_dec[2:0], 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (rvalid) begin
      unique case (r_state)
        ST_IDLE:    if (w_class == BC_DATA) w_next_state = ST_COLLECT;
        ST_COLLECT: begin
          if (w_class == BC_TERM)                                w_next_state = ST_IDLE;
          else if (w_class == BC_BS && r_acnt == 4'd1)           w_next_state = ST_IDLE;
          else if (w_class == BC_DATA && r_acnt == LINE_BYTES_W) w_next_state = ST_DISCARD;
        end
        ST_DISCARD: if (w_class == BC_TERM) w_next_state = ST_IDLE;
        default:    w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_store    = 1'b0;
    w_unstore  = 1'b0;
    w_deliver  = 1'b0;
    w_clear    = 1'b0;
    w_line_ovf = 1'b0;
    if (rvalid) begin
      unique case (r_state)
        ST_IDLE: begin
          w_store   = (w_class == BC_DATA);
          w_deliver = (w_class == BC_TERM) && !DROP_EMPTY;
        end
        ST_COLLECT: begin
          w_store   = (w_class == BC_DATA) && (r_acnt != LINE_BYTES_W);
          w_unstore = (w_class == BC_BS);
          w_deliver = (w_class == BC_TERM);
          w_clear   = (w_class == BC_TERM);
        end
        ST_DISCARD: begin
          w_deliver  = (w_class == BC_TERM);
          w_clear    = (w_class == BC_TERM);
          w_line_ovf = (w_class == BC_TERM);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abuf <= 64'd0;
      r_acnt <= 4'd0;
    end else if (w_clear) begin
      r_abuf <= 64'd0;
      r_acnt <= 4'd0;
    end else if (w_store) begin
      r_abuf <= r_abuf | w_ins;
      r_acnt <= r_acnt + 4'd1;
    end else if (w_unstore) begin
      r_abuf <= r_abuf & ~w_del_mask;
      r_acnt <= w_acnt_dec;
    end
  end

  // An acknowledge in the same cycle as a delivery frees the register for the new line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lbuf    <= 64'd0;
      r_llen    <= 4'd0;
      r_lovf    <= 1'b0;
      r_lvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_deliver) begin
      if (!r_lvalid || lack) begin
        r_lbuf   <= r_abuf;
        r_llen   <= w_line_ovf ? LINE_BYTES_W : r_acnt;
        r_lovf   <= w_line_ovf;
        r_lvalid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (lack && r_lvalid) begin
      r_lvalid <= 1'b0;
    end
  end

  assign lbuf    = r_lbuf;
  assign llen    = r_llen;
  assign lovf    = r_lovf;
  assign lvalid  = r_lvalid;
  assign overrun = r_overrun;

endmodule
